// File: rtl/byte_register_pkg.sv
// Shared types for byte_register: operation encoding and enable-priority decode.
package byte_register_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_ROTR = 2'd1,
    OP_INC  = 2'd2,
    OP_LOAD = 2'd3
  } op_e;

  // Fixed priority: load > inc > rotate_right > hold; enables never combine.
  function automatic op_e sel_op(input logic load, input logic inc, input logic rotate_right);
    if (load)              return OP_LOAD;
    else if (inc)          return OP_INC;
    else if (rotate_right) return OP_ROTR;
    else                   return OP_HOLD;
  endfunction

endpackage

// File: rtl/byte_register_next.sv
// Combinational next-state logic for byte_register.
// Optional carry path built only when BYTE_REGISTER_FLAGS_EN is defined.
module byte_register_next
  import byte_register_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
`ifdef BYTE_REGISTER_FLAGS_EN
  input  logic             carry,
  output logic             carry_next,
`endif
  output logic [WIDTH-1:0] q_next
);

  always_comb begin
    q_next = q;
    unique case (op)
      OP_LOAD: q_next = d;
      OP_INC:  q_next = q + 1'b1;
      OP_ROTR: q_next = {q[0], q[WIDTH-1:1]};
      default: q_next = q;
    endcase
  end

`ifdef BYTE_REGISTER_FLAGS_EN
  // Carry records only an increment that wrapped; every other update clears it.
  always_comb begin
    carry_next = carry;
    unique case (op)
      OP_INC:  carry_next = &q;
      OP_LOAD,
      OP_ROTR: carry_next = 1'b0;
      default: carry_next = carry;
    endcase
  end
`endif

endmodule

// File: rtl/byte_register.sv
// WIDTH-bit datapath register: load > inc > rotate_right > hold, sync active-high reset.
// Define BYTE_REGISTER_FLAGS_EN to add the zero and carry flag outputs.
module byte_register
  import byte_register_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             inc,
  input  logic             rotate_right,
  input  logic [WIDTH-1:0] D,
`ifdef BYTE_REGISTER_FLAGS_EN
  output logic             zero,
  output logic             carry,
`endif
  output logic [WIDTH-1:0] Q
);

  op_e              op;
  logic [WIDTH-1:0] q_next;

  assign op = sel_op(load, inc, rotate_right);

`ifdef BYTE_REGISTER_FLAGS_EN
  logic carry_next;

  byte_register_next #(.WIDTH(WIDTH)) u_next (
    .op         (op),
    .q          (Q),
    .d          (D),
    .carry      (carry),
    .carry_next (carry_next),
    .q_next     (q_next)
  );

  always_ff @(posedge clk) begin
    if (reset) carry <= 1'b0;
    else       carry <= carry_next;
  end

  assign zero = (Q == '0);
`else
  byte_register_next #(.WIDTH(WIDTH)) u_next (
    .op     (op),
    .q      (Q),
    .d      (D),
    .q_next (q_next)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) Q <= RESET_VALUE;
    else       Q <= q_next;
  end

endmodule

// File: tb/tb_byte_register.sv
// Directed self-checking bench for byte_register (flag checks when BYTE_REGISTER_FLAGS_EN is defined).
module tb_byte_register;

  logic       clk = 1'b0;
  logic       reset, load, inc, rotate_right;
  logic [7:0] D;
  logic [7:0] Q;
`ifdef BYTE_REGISTER_FLAGS_EN
  logic       zero, carry;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  byte_register #(.WIDTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .inc          (inc),
    .rotate_right (rotate_right),
    .D            (D),
`ifdef BYTE_REGISTER_FLAGS_EN
    .zero         (zero),
    .carry        (carry),
`endif
    .Q            (Q)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive controls, let one rising edge pass, return at the following negedge.
  task automatic step(input logic r, input logic ld, input logic in, input logic rr, input logic [7:0] d);
    reset = r; load = ld; inc = in; rotate_right = rr; D = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_flags(input string tag, input logic z, input logic c);
`ifdef BYTE_REGISTER_FLAGS_EN
    chk({tag, "_zero"}, zero, z);
    chk({tag, "_carry"}, carry, c);
`endif
  endtask

  initial begin
    reset = 1'b0; load = 1'b0; inc = 1'b0; rotate_right = 1'b0; D = 8'h00;
    @(negedge clk);

    // Reset wins over load
    step(1, 1, 0, 0, 8'h5A); chk("rst_over_load", Q, 8'h00);
    chk_flags("rst", 1'b1, 1'b0);
    step(0, 0, 0, 0, 8'h00); chk("hold_after_rst", Q, 8'h00);

    // Load, inc, rotate, hold
    step(0, 1, 0, 0, 8'hA5); chk("load_a5", Q, 8'hA5);
    step(0, 0, 1, 0, 8'h00); chk("inc_a6", Q, 8'hA6);
    step(0, 0, 0, 1, 8'h00); chk("rotr_53", Q, 8'h53);
    step(0, 0, 0, 0, 8'hFF); chk("hold_53", Q, 8'h53);

    // Reset raised mid-cycle takes effect only at the next edge
    reset = 1'b1;
    #2;
    chk("rst_midcycle_no_effect", Q, 8'h53);
    @(posedge clk); @(negedge clk);
    chk("rst_midcycle_edge", Q, 8'h00);

    // Priority
    step(0, 1, 1, 0, 8'h3C); chk("load_over_inc", Q, 8'h3C);
    step(0, 0, 1, 1, 8'h3C); chk("inc_over_rotr", Q, 8'h3D);
    step(0, 1, 1, 1, 8'h11); chk("load_over_all", Q, 8'h11);
    step(0, 0, 1, 0, 8'hFF); chk("inc_ignores_d", Q, 8'h12);

    // Wrap and flags
    step(0, 1, 0, 0, 8'hFF); chk("load_ff", Q, 8'hFF);
    chk_flags("load_ff", 1'b0, 1'b0);
    step(0, 0, 1, 0, 8'h00); chk("wrap_00", Q, 8'h00);
    chk_flags("wrap", 1'b1, 1'b1);
    step(0, 0, 0, 0, 8'h00); chk("hold_00", Q, 8'h00);
    chk_flags("hold_carry", 1'b1, 1'b1);
    step(0, 0, 1, 0, 8'h00); chk("inc_01", Q, 8'h01);
    chk_flags("inc_after_wrap", 1'b0, 1'b0);
    step(0, 1, 0, 0, 8'hFF); step(0, 0, 1, 0, 8'h00);
    step(0, 0, 0, 1, 8'h00); chk("rotr_zero", Q, 8'h00);
    chk_flags("rotr_clears_carry", 1'b1, 1'b0);

    // Rotate boundaries
    step(0, 1, 0, 0, 8'h01); step(0, 0, 0, 1, 8'h00); chk("rotr_lsb_to_msb", Q, 8'h80);
    step(0, 1, 0, 0, 8'hA5); step(0, 0, 0, 1, 8'h00); chk("rotr_a5_once", Q, 8'hD2);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 8'h00);
    chk("rotr_a5_eight", Q, 8'hA5);

    // Reset mid-operation beats inc
    step(0, 1, 0, 0, 8'h3D); chk("load_3d", Q, 8'h3D);
    step(1, 0, 1, 0, 8'h00); chk("rst_over_inc", Q, 8'h00);
    step(1, 0, 1, 0, 8'h00); chk("rst_held", Q, 8'h00);
    step(0, 0, 1, 0, 8'h00); chk("inc_after_rst", Q, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/byte_register.md
Name: byte_register

Overview:
- General-purpose WIDTH-bit (default 8) datapath register with parallel load, increment and circular rotate-right.
- Enables are prioritised: load > inc > rotate_right > hold.
- Used as an accumulator, counter or shift register inside the CPU datapath.
- Output is the registered value, visible combinationally on Q.

Parameters:
- WIDTH, 8, register width in bits (legal range ≥ 2).
- RESET_VALUE, '0 (all zeros), value loaded into Q on reset.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- load  input  1  parallel-load enable
- inc  input  1  increment enable
- rotate_right  input  1  circular rotate-right enable
- D  input  WIDTH  parallel load data
- Q  output  WIDTH  current register contents
- zero  output  1  only with BYTE_REGISTER_FLAGS_EN
- carry  output  1  only with BYTE_REGISTER_FLAGS_EN

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- All state updates occur on rising edge of clk only; no asynchronous paths into Q.
- Reset:
  - reset=1 at a rising edge → Q <= RESET_VALUE (zeros by default).
  - Reset overrides all enables.
  - Reset asserted mid-cycle has no effect until the next rising edge.
  - Q stays at RESET_VALUE while reset is held.
- Per-edge priority when reset=0:
  1. load=1 → Q <= D. Wins over inc and rotate_right.
  2. else inc=1 → Q <= Q + 1, modulo 2^WIDTH (8'hFF wraps to 8'h00). Wins over rotate_right.
  3. else rotate_right=1 → Q <= {Q[0], Q[WIDTH-1:1]}. LSB moves to MSB; no bits lost.
  4. else hold → Q unchanged.
- Latency: one cycle. New value is visible on Q immediately after the updating edge (sampled on the following negedge in benches).
- Simultaneous enables never combine (e.g. load+inc loads D; no increment is applied).
- D is ignored unless load wins the priority.
- No X-propagation tolerance required. Enables are assumed 0/1 after reset.

Optional Feature:
- Macro: BYTE_REGISTER_FLAGS_EN.
- When defined, ports zero and carry exist:
  - zero = (Q == 0), combinational from Q.
  - carry is a registered bit:
    - reset clears it to 0.
    - Set to 1 on an inc update where Q was all-ones (wrap).
    - Cleared to 0 on any non-wrapping inc, any load, or any rotate_right.
    - Held on hold cycles.
- When undefined: ports zero and carry are absent, no carry flop is built, and behaviour of Q is identical.

Decomposition:
- Package byte_register_pkg:
  - typedef enum logic [1:0] op_e {OP_HOLD, OP_ROTR, OP_INC, OP_LOAD}.
  - Function that maps (load, inc, rotate_right) to op_e using the fixed priority.
- One sub-module, byte_register_next: purely combinational.
  - Inputs: op_e, Q, D.
  - Outputs: next value and (with flags) next carry.
  - Top level holds only the flops and the reset mux.

Test Plan:
- Reset: reset=1 for one edge with load=1, D=8'h5A → Q=8'h00. Release reset, hold one cycle → Q=8'h00. Reset raised mid-cycle leaves Q unchanged until the next edge.
- Load then inc: D=8'hA5, load=1 → Q=8'hA5. Then inc=1 → Q=8'hA6. Then rotate_right=1 → Q=8'h53. Then no enables → Q=8'h53.
- Priority: load=inc=1, D=8'h3C → Q=8'h3C. Then inc=rotate_right=1 → Q=8'h3D. All three set with D=8'h11 → Q=8'h11.
- Wrap: load 8'hFF, inc → Q=8'h00. With flags: carry=1, zero=1. Next inc → Q=8'h01, carry=0, zero=0.
- Rotate boundary: load 8'h01, rotate_right → Q=8'h80. Eight consecutive rotates from 8'hA5 → back to 8'hA5.
- Reset mid-operation: Q=8'h3D, assert reset with inc=1 at the same edge → Q=8'h00. Deassert, then inc → Q=8'h01.
